// File: rtl/mips_reg_dump_if.sv
// Register-file debug read port plus the valid/ready dump stream carried by mips_reg_dump.
// master = dump engine, slave = register file / stream consumer side.
interface mips_reg_dump_if;
  logic [4:0]  ra3;
  logic [31:0] rd3;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_idx;
  logic [31:0] dump_data;

  modport master (
    output ra3,
    input  rd3,
    output dump_valid,
    input  dump_ready,
    output dump_idx,
    output dump_data
  );

  modport slave (
    input  ra3,
    output rd3,
    input  dump_valid,
    output dump_ready,
    input  dump_idx,
    input  dump_data
  );
endinterface

// File: rtl/mips_reg_dump.sv
// Runs a program until HALT_PC, drains, then streams all 32 registers out (2 cycles/beat min);
// first beat DRAIN_CYCLES+2 cycles after the halt match; SEND holds its beat until dump_ready.
module mips_reg_dump #(
  parameter logic [31:0] HALT_PC        = 32'h0000_0100,
  parameter int unsigned DRAIN_CYCLES   = 5,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [31:0]        pc_current,
  mips_reg_dump_if.master    dbg,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_ADDR  = 3'd3,
    S_SEND  = 3'd4,
    S_DONE  = 3'd5,
    S_TMO   = 3'd6
  } state_t;

  localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);
  localparam logic [31:0] DRAIN_LAST = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cycles;
  logic [31:0] r_wait;
  logic [4:0]  r_idx;
  logic [4:0]  r_ra3;
  logic [4:0]  r_dump_idx;
  logic [31:0] r_dump_data;

  logic [31:0] w_cyc_inc;
  logic        w_xfer;
  logic        w_last;
  logic [4:0]  w_addr_idx;

  assign w_cyc_inc  = r_cycles + 32'd1;
  assign w_xfer     = (r_state == S_SEND) && dbg.dump_ready;
  assign w_last     = (r_idx == 5'd31);
  assign w_addr_idx = (r_state == S_SEND) ? (r_idx + 5'd1) : 5'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_TMO: begin
        if (start) w_next = S_RUN;
      end
      S_RUN: begin
        // Halt match is checked first so it wins over a same-cycle timeout.
        if (pc_current == HALT_PC) begin
          w_next = (DRAIN_CYCLES == 0) ? S_ADDR : S_DRAIN;
        end else if (w_cyc_inc >= TMO_LIMIT) begin
          w_next = S_TMO;
        end
      end
      S_DRAIN: begin
        if (r_wait == DRAIN_LAST) w_next = S_ADDR;
      end
      S_ADDR: begin
        w_next = S_SEND;
      end
      S_SEND: begin
        if (w_xfer) w_next = w_last ? S_DONE : S_ADDR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycles    <= 32'd0;
      r_wait      <= 32'd0;
      r_idx       <= 5'd0;
      r_ra3       <= 5'd0;
      r_dump_idx  <= 5'd0;
      r_dump_data <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_TMO: begin
          if (start) r_cycles <= 32'd0;
        end
        S_RUN: begin
          r_cycles <= w_cyc_inc;
          r_wait   <= 32'd0;
          r_idx    <= 5'd0;
        end
        S_DRAIN: begin
          r_wait <= r_wait + 32'd1;
        end
        S_ADDR: begin
          r_dump_data <= dbg.rd3;
          r_dump_idx  <= r_idx;
        end
        S_SEND: begin
          if (w_xfer && !w_last) r_idx <= r_idx + 5'd1;
        end
        default: begin
        end
      endcase
      // ra3 is registered and only moves when an ADDR cycle is about to start.
      if (w_next == S_ADDR) r_ra3 <= w_addr_idx;
    end
  end

  assign dbg.ra3        = r_ra3;
  assign dbg.dump_valid = (r_state == S_SEND);
  assign dbg.dump_idx   = r_dump_idx;
  assign dbg.dump_data  = r_dump_data;

  assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN) ||
                   (r_state == S_ADDR) || (r_state == S_SEND);
  assign done    = (r_state == S_DONE);
  assign timeout = (r_state == S_TMO);

endmodule

// File: doc/mips_reg_dump.md
MIPS_REG_DUMP -- requirements
Module: mips_reg_dump

Interface
REQ-001 Parameter HALT_PC, default 32'h0000_0100, PC value that marks program completion.
REQ-002 Parameter DRAIN_CYCLES, default 5, cycles waited after halt detection before register reads begin.
REQ-003 Parameter TIMEOUT_CYCLES, default 2000, maximum run cycles before the timeout flag is set.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 start  input  1  one-cycle pulse that arms a run.
REQ-007 pc_current  input  32  SoC program counter.
REQ-008 ra3  output  5  register-file debug read address.
REQ-009 rd3  input  32  register-file debug read data, combinational from ra3.
REQ-010 dump_valid  output  1  dump_data/dump_idx hold a register value.
REQ-011 dump_ready  input  1  consumer accepts the current beat.
REQ-012 dump_idx  output  5  register index of the current beat.
REQ-013 dump_data  output  32  register value of the current beat.
REQ-014 busy  output  1  high in RUN, DRAIN, ADDR and SEND.
REQ-015 done  output  1  all 32 registers delivered.
REQ-016 timeout  output  1  halt PC not reached within TIMEOUT_CYCLES.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN, ADDR, SEND, DONE and TMO.
REQ-018 IDLE: on start=1, go to RUN and clear the cycle counter, done and timeout.
REQ-019 RUN: the 32-bit cycle counter SHALL increment once per cycle.
REQ-020 RUN: pc_current==HALT_PC goes to DRAIN; otherwise, when the counter reaches TIMEOUT_CYCLES, go to TMO.
REQ-021 RUN: if the halt match and the timeout limit occur in the same cycle, the halt match SHALL take priority.
REQ-022 DRAIN: wait exactly DRAIN_CYCLES cycles, then go to ADDR with the index at 0.
REQ-023 DRAIN: DRAIN_CYCLES=0 SHALL go directly to ADDR on the next cycle.
REQ-024 ADDR: drive ra3=index for one cycle.
REQ-025 ADDR: on the next edge, capture rd3 into dump_data and index into dump_idx, then go to SEND.
REQ-026 SEND: hold dump_valid=1 with dump_data and dump_idx stable until dump_ready=1.
REQ-027 SEND: a transfer occurs on a cycle with dump_valid&&dump_ready; dump_valid SHALL NOT depend combinationally on dump_ready.
REQ-028 On transfer: if index==31, go to DONE; otherwise increment index and go to ADDR.
REQ-029 Rate: minimum 2 cycles per beat; 64 cycles minimum for a full dump.
REQ-030 Ordering: exactly 32 beats, indices 0..31 in ascending order, no repeats; register 0 is included.
REQ-031 ra3 SHALL hold its last value outside ADDR.
REQ-032 DONE: done=1, busy=0; hold until start=1, which re-enters RUN with done cleared.
REQ-033 TMO: timeout=1, busy=0, no beats issued; hold until start=1, which re-enters RUN with timeout cleared.
REQ-034 start SHALL be ignored in RUN, DRAIN, ADDR and SEND.
REQ-035 dump_valid SHALL be 0 in every state except SEND.

Reset
REQ-036 While rst=0, the block SHALL asynchronously force IDLE.
REQ-037 While rst=0, ra3, dump_idx, dump_data, the index and the cycle counter SHALL be 0.
REQ-038 While rst=0, dump_valid, busy, done and timeout SHALL be 0.
REQ-039 Reset asserted in any state, including mid-handshake in SEND, SHALL abort the dump with no further beats.
REQ-040 Operation after reset release SHALL require a new start pulse.

Verification
REQ-041 Nominal: start; pc_current reaches 32'h100 at run cycle 40; dump_ready=1 always; register r holds r*3 -> 32 beats (idx r, data r*3), first beat 7 cycles after the match, done=1 after 64 beat cycles.
REQ-042 Backpressure: dump_ready low for 3 cycles on beat 5 -> dump_valid and dump_data hold 15 with dump_idx 5; beat 6 follows only after acceptance.
REQ-043 Timeout: TIMEOUT_CYCLES=10 and pc_current never 32'h100 -> timeout=1 after 10 run cycles, dump_valid never asserted, busy=0.
REQ-044 Simultaneous events: halt match on the same cycle the counter hits the limit -> DRAIN entered, timeout stays 0.
REQ-045 Reset mid-dump: rst=0 during SEND of beat 12 -> all outputs 0 immediately; after release, no beats until start.
REQ-046 Restart: start in DONE -> done clears next cycle and a full second 32-beat dump completes.
